// File: rtl/tick_scheduler_if.sv
// Control and status bundle for the tick scheduler.
// The master drives the run/beep requests and the slave returns the timebase outputs.
interface tick_scheduler_if #(
  parameter int PW = 4
);
  logic          enable;
  logic [PW-1:0] phase;
  logic          beep_en;
  logic          tick;
  logic          tick_lvl;
  logic          beep;
  logic          running;
  logic [1:0]    state;

  modport master (
    output enable, phase, beep_en,
    input  tick, tick_lvl, beep, running, state
  );

  modport slave (
    input  enable, phase, beep_en,
    output tick, tick_lvl, beep, running, state
  );
endinterface

// File: rtl/tick_scheduler.sv
// Alarm-clock timebase: periodic tick, duty-controlled level and gated buzzer tone from clk.
//   state | meaning
//   IDLE  | stopped, all outputs low
//   ARM   | counting down the latched start-phase delay
//   RUN   | period counter running, tick on every wrap
//   STOP  | finishing the current period, wrap tick suppressed
module tick_scheduler #(
  parameter int CLK_HZ  = 10_000_000,
  parameter int TICK_HZ = 1,
  parameter int DUTY    = 50,
  parameter int BEEP_HZ = 2000
) (
  input  logic              clk,
  input  logic              rst_n,
  tick_scheduler_if.slave   io_bus
);
  localparam int PERIOD = CLK_HZ / TICK_HZ;
  localparam int ON     = int'((longint'(PERIOD) * longint'(DUTY)) / 100);
  localparam int HALF   = CLK_HZ / (2 * BEEP_HZ);
  localparam int PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int BW     = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [PW-1:0] P_LAST    = PW'(PERIOD - 1);
  localparam logic [PW-1:0] ON_C      = PW'(ON);
  localparam logic [BW-1:0] HALF_LAST = BW'(HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_STOP = 2'd3
  } state_t;

  logic          r_enable;
  logic [PW-1:0] r_phase;
  logic          r_beep_en;

  state_t        r_state;
  logic [PW-1:0] r_pcnt;
  logic [PW-1:0] r_acnt;
  logic [BW-1:0] r_bcnt;
  logic          r_tick;
  logic          r_tick_lvl;
  logic          r_beep;
  logic          r_running;

  state_t        w_state_nxt;
  logic [PW-1:0] w_pcnt_nxt;
  logic [PW-1:0] w_acnt_nxt;
  logic [BW-1:0] w_bcnt_nxt;
  logic [PW-1:0] w_pcnt_inc;
  logic [PW-1:0] w_dly;
  logic          w_run_nxt;
  logic          w_tick_nxt;
  logic          w_lvl_nxt;
  logic          w_beep_nxt;
  logic          w_bact;

  // Requests are captured first and acted on one edge later, so every
  // response is measured from the edge that sampled the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable  <= 1'b0;
      r_phase   <= '0;
      r_beep_en <= 1'b0;
    end else begin
      r_enable  <= io_bus.enable;
      r_phase   <= io_bus.phase;
      r_beep_en <= io_bus.beep_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pcnt     <= '0;
      r_acnt     <= '0;
      r_bcnt     <= '0;
      r_tick     <= 1'b0;
      r_tick_lvl <= 1'b0;
      r_beep     <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pcnt     <= w_pcnt_nxt;
      r_acnt     <= w_acnt_nxt;
      r_bcnt     <= w_bcnt_nxt;
      r_tick     <= w_tick_nxt;
      r_tick_lvl <= w_lvl_nxt;
      r_beep     <= w_beep_nxt;
      r_running  <= w_run_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    w_acnt_nxt  = r_acnt;
    w_pcnt_inc  = (r_pcnt == P_LAST) ? '0 : r_pcnt + 1'b1;
    w_dly       = (r_phase > P_LAST) ? P_LAST : r_phase;

    case (r_state)
      S_IDLE: begin
        w_pcnt_nxt = '0;
        w_acnt_nxt = '0;
        if (r_enable) begin
          if (w_dly == '0) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_ARM;
            w_acnt_nxt  = w_dly - 1'b1;
          end
        end
      end
      S_ARM: begin
        if (!r_enable) begin
          w_state_nxt = S_IDLE;
          w_acnt_nxt  = '0;
        end else if (r_acnt == '0) begin
          w_state_nxt = S_RUN;
          w_pcnt_nxt  = '0;
        end else begin
          w_acnt_nxt = r_acnt - 1'b1;
        end
      end
      S_RUN: begin
        // A stop request on the last cycle of a period ends it right there.
        if (r_enable) begin
          w_pcnt_nxt = w_pcnt_inc;
        end else if (r_pcnt == P_LAST) begin
          w_state_nxt = S_IDLE;
          w_pcnt_nxt  = '0;
        end else begin
          w_state_nxt = S_STOP;
          w_pcnt_nxt  = w_pcnt_inc;
        end
      end
      S_STOP: begin
        if (r_enable) begin
          w_state_nxt = S_RUN;
          w_pcnt_nxt  = w_pcnt_inc;
        end else if (r_pcnt == P_LAST) begin
          w_state_nxt = S_IDLE;
          w_pcnt_nxt  = '0;
        end else begin
          w_pcnt_nxt = w_pcnt_inc;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pcnt_nxt  = '0;
        w_acnt_nxt  = '0;
      end
    endcase

    w_run_nxt  = (w_state_nxt == S_RUN) || (w_state_nxt == S_STOP);
    w_tick_nxt = (w_state_nxt == S_RUN) && (w_pcnt_nxt == '0);
    w_lvl_nxt  = w_run_nxt && (w_pcnt_nxt < ON_C);

    // Tone starts high: the first active edge sees bcnt at zero and toggles.
    w_bact = w_run_nxt && r_beep_en;
    if (!w_bact) begin
      w_bcnt_nxt = '0;
      w_beep_nxt = 1'b0;
    end else if (r_bcnt == '0) begin
      w_bcnt_nxt = HALF_LAST;
      w_beep_nxt = ~r_beep;
    end else begin
      w_bcnt_nxt = r_bcnt - 1'b1;
      w_beep_nxt = r_beep;
    end
  end

  assign io_bus.tick     = r_tick;
  assign io_bus.tick_lvl = r_tick_lvl;
  assign io_bus.beep     = r_beep;
  assign io_bus.running  = r_running;
  assign io_bus.state    = r_state;
endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with PERIOD=10, ON=3, HALF=2.
module tb_tick_scheduler;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  tick_scheduler_if #(.PW(4)) bus ();

  tick_scheduler #(
    .CLK_HZ (100),
    .TICK_HZ(10),
    .DUTY   (30),
    .BEEP_HZ(25)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit reached");
  end

  // Advance one rising edge and land on the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    bus.enable  = 1'b0;
    bus.beep_en = 1'b0;
    for (int i = 0; i < 40 && bus.state !== 2'd0; i++) cyc();
    total++;
    if (bus.state !== 2'd0) begin
      bad++;
      $display("FAIL drain_idle got=%0d exp=0", bus.state);
    end
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    logic seen;
    rst_n = 1'b1;
    bus.enable = 1'b1;
    bus.phase = 4'd0;
    bus.beep_en = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.tick, bus.tick_lvl, bus.beep, bus.running, bus.state} !== 6'b0) begin
      bad++;
      $display("FAIL reset_async got=%b exp=000000",
               {bus.tick, bus.tick_lvl, bus.beep, bus.running, bus.state});
    end
    for (int i = 0; i < 3; i++) cyc();
    total++;
    if ({bus.tick, bus.tick_lvl, bus.beep, bus.running, bus.state} !== 6'b0) begin
      bad++;
      $display("FAIL reset_held got=%b exp=000000",
               {bus.tick, bus.tick_lvl, bus.beep, bus.running, bus.state});
    end
    bus.enable = 1'b0;
    bus.beep_en = 1'b0;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (bus.tick === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_tick got=%b exp=0", seen);
    end
    total++;
    if (bus.state !== 2'd0) begin
      bad++;
      $display("FAIL reset_idle got=%0d exp=0", bus.state);
    end
  endtask

  task automatic test_phase0();
    logic       et, el, er;
    logic [1:0] es;
    bus.phase = 4'd0;
    bus.enable = 1'b1;
    for (int k = 0; k <= 22; k++) begin
      cyc();
      et = (k >= 1) && (((k - 1) % 10) == 0);
      el = (k >= 1) && (((k - 1) % 10) < 3);
      er = (k >= 1);
      es = (k >= 1) ? 2'd2 : 2'd0;
      total++;
      if (bus.tick !== et) begin
        bad++;
        $display("FAIL phase0_tick k=%0d got=%b exp=%b", k, bus.tick, et);
      end
      total++;
      if (bus.tick_lvl !== el) begin
        bad++;
        $display("FAIL phase0_lvl k=%0d got=%b exp=%b", k, bus.tick_lvl, el);
      end
      total++;
      if (bus.running !== er) begin
        bad++;
        $display("FAIL phase0_running k=%0d got=%b exp=%b", k, bus.running, er);
      end
      total++;
      if (bus.state !== es) begin
        bad++;
        $display("FAIL phase0_state k=%0d got=%0d exp=%0d", k, bus.state, es);
      end
    end
    drain();
  endtask

  task automatic test_arm();
    logic       et, seen;
    logic [1:0] es;
    bus.phase = 4'd4;
    bus.enable = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      cyc();
      et = (k == 5) || (k == 15);
      es = (k == 0) ? 2'd0 : ((k <= 4) ? 2'd1 : 2'd2);
      total++;
      if (bus.tick !== et) begin
        bad++;
        $display("FAIL arm_tick k=%0d got=%b exp=%b", k, bus.tick, et);
      end
      total++;
      if (bus.state !== es) begin
        bad++;
        $display("FAIL arm_state k=%0d got=%0d exp=%0d", k, bus.state, es);
      end
    end
    drain();

    bus.phase = 4'd4;
    bus.enable = 1'b1;
    seen = 1'b0;
    for (int k = 0; k <= 2; k++) begin
      cyc();
      if (bus.tick === 1'b1) seen = 1'b1;
    end
    bus.enable = 1'b0;
    cyc();
    if (bus.tick === 1'b1) seen = 1'b1;
    total++;
    if (bus.state !== 2'd1) begin
      bad++;
      $display("FAIL arm_abort_armed got=%0d exp=1", bus.state);
    end
    cyc();
    total++;
    if (bus.state !== 2'd0) begin
      bad++;
      $display("FAIL arm_abort_idle got=%0d exp=0", bus.state);
    end
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (bus.tick === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL arm_abort_no_tick got=%b exp=0", seen);
    end
  endtask

  task automatic test_graceful_stop();
    logic       er;
    logic [1:0] es;
    bus.phase = 4'd0;
    bus.enable = 1'b1;
    cyc();
    cyc();
    total++;
    if (bus.tick !== 1'b1) begin
      bad++;
      $display("FAIL stop_first_tick got=%b exp=1", bus.tick);
    end
    for (int j = 1; j <= 3; j++) cyc();
    bus.enable = 1'b0;
    for (int j = 4; j <= 11; j++) begin
      cyc();
      er = (j <= 9);
      total++;
      if (bus.tick !== 1'b0) begin
        bad++;
        $display("FAIL stop_tick j=%0d got=%b exp=0", j, bus.tick);
      end
      total++;
      if (bus.running !== er) begin
        bad++;
        $display("FAIL stop_running j=%0d got=%b exp=%b", j, bus.running, er);
      end
      if (j >= 5) begin
        es = (j <= 9) ? 2'd3 : 2'd0;
        total++;
        if (bus.state !== es) begin
          bad++;
          $display("FAIL stop_state j=%0d got=%0d exp=%0d", j, bus.state, es);
        end
      end
    end
    drain();

    bus.phase = 4'd0;
    bus.enable = 1'b1;
    cyc();
    cyc();
    total++;
    if (bus.tick !== 1'b1) begin
      bad++;
      $display("FAIL resume_first_tick got=%b exp=1", bus.tick);
    end
    for (int j = 1; j <= 3; j++) cyc();
    bus.enable = 1'b0;
    cyc();
    cyc();
    bus.enable = 1'b1;
    for (int j = 6; j <= 21; j++) begin
      cyc();
      total++;
      if (bus.tick !== ((j == 10) || (j == 20))) begin
        bad++;
        $display("FAIL resume_tick j=%0d got=%b exp=%b", j, bus.tick, (j == 10) || (j == 20));
      end
      es = (j == 6) ? 2'd3 : 2'd2;
      total++;
      if (bus.state !== es) begin
        bad++;
        $display("FAIL resume_state j=%0d got=%0d exp=%0d", j, bus.state, es);
      end
    end
    drain();
  endtask

  task automatic test_beep();
    logic eb, seen;
    bus.phase = 4'd0;
    bus.enable = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    bus.beep_en = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      cyc();
      eb = (k >= 1) && ((((k - 1) / 2) % 2) == 0);
      total++;
      if (bus.beep !== eb) begin
        bad++;
        $display("FAIL beep_wave k=%0d got=%b exp=%b", k, bus.beep, eb);
      end
    end
    bus.beep_en = 1'b0;
    cyc();
    cyc();
    total++;
    if (bus.beep !== 1'b0) begin
      bad++;
      $display("FAIL beep_off got=%b exp=0", bus.beep);
    end
    drain();

    bus.beep_en = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (bus.beep === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL beep_idle got=%b exp=0", seen);
    end
    bus.beep_en = 1'b0;
  endtask

  task automatic test_boundary();
    logic [1:0] es;
    bus.phase = 4'd15;
    bus.enable = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      cyc();
      total++;
      if (bus.tick !== (k == 10)) begin
        bad++;
        $display("FAIL sat_tick k=%0d got=%b exp=%b", k, bus.tick, k == 10);
      end
      if (k >= 1) begin
        es = (k <= 9) ? 2'd1 : 2'd2;
        total++;
        if (bus.state !== es) begin
          bad++;
          $display("FAIL sat_state k=%0d got=%0d exp=%0d", k, bus.state, es);
        end
      end
    end
    drain();

    bus.phase = 4'd0;
    bus.enable = 1'b1;
    cyc();
    cyc();
    total++;
    if (bus.tick_lvl !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre_lvl got=%b exp=1", bus.tick_lvl);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.tick, bus.tick_lvl, bus.beep, bus.running, bus.state} !== 6'b0) begin
      bad++;
      $display("FAIL midrst_async got=%b exp=000000",
               {bus.tick, bus.tick_lvl, bus.beep, bus.running, bus.state});
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    total++;
    if (bus.tick !== 1'b0 || bus.state !== 2'd0) begin
      bad++;
      $display("FAIL midrst_first_edge tick=%b state=%0d exp tick=0 state=0", bus.tick, bus.state);
    end
    cyc();
    total++;
    if (bus.tick !== 1'b1 || bus.state !== 2'd2) begin
      bad++;
      $display("FAIL midrst_restart tick=%b state=%0d exp tick=1 state=2", bus.tick, bus.state);
    end
    drain();
  endtask

  initial begin
    total = 0;
    bad = 0;
    bus.enable = 1'b0;
    bus.phase = 4'd0;
    bus.beep_en = 1'b0;
    test_reset();
    test_phase0();
    test_arm();
    test_graceful_stop();
    test_beep();
    test_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
